iommu_fq_writer: RTL and testbench

- Downstream consumer of the fault-record FIFO. Pops one fault record at a time and writes it into the software-visible circular fault queue in memory.
- Owns the queue tail pointer, detects queue-full overflow and memory write faults, and raises the fault-pending flag.
- Sits between the fault-record FIFO and the IOMMU memory write port.

---
 rtl/iommu_fq_writer.sv | 167 ++++++++++++++++
 tb/tb_iommu_fq_writer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iommu_fq_writer.sv
// Drains fault records from the record FIFO into the in-memory circular fault queue.
// Build option: define IOMMU_FQ_IRQ_CLR_EN to add clr_fip_i (software clear of fip_o).
module iommu_fq_writer #(
  parameter int RECORD_W = 256,
  parameter int PPN_W    = 44,
  parameter int ADDR_W   = 56,
  parameter int IDX_W    = 20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic [PPN_W-1:0]    base_ppn_i,
  input  logic [4:0]          log2sz_i,
  input  logic [IDX_W-1:0]    head_i,
  output logic [IDX_W-1:0]    tail_o,
  input  logic                fifo_empty_i,
  input  logic [RECORD_W-1:0] fifo_data_i,
  output logic                fifo_pop_o,
  output logic                wr_valid_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [RECORD_W-1:0] wr_data_o,
  input  logic                wr_ready_i,
  input  logic                wr_resp_valid_i,
  input  logic                wr_resp_err_i,
  input  logic                clr_of_i,
  input  logic                clr_mf_i,
`ifdef IOMMU_FQ_IRQ_CLR_EN
  input  logic                clr_fip_i,
`endif
  output logic                overflow_o,
  output logic                mem_fault_o,
  output logic                fip_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    tail_q, tail_d;
  logic                pop_q, pop_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [RECORD_W-1:0] data_q, data_d;
  logic                of_q, of_d;
  logic                mf_q, mf_d;
  logic                fip_q, fip_d;
  logic                en_q;

  logic [5:0]          size_log2;
  logic [IDX_W-1:0]    mask;
  logic [IDX_W-1:0]    next_tail;
  logic [ADDR_W-1:0]   tail_addr;
  logic                full;
  logic                set_of, set_mf, set_fip, tail_adv;
  logic                en_fall, clr_fip;

`ifdef IOMMU_FQ_IRQ_CLR_EN
  assign clr_fip = clr_fip_i;
`else
  assign clr_fip = 1'b0;
`endif

  // Queue holds 2^(log2sz+1) entries, clamped to what the index can address.
  always_comb begin
    size_log2 = {1'b0, log2sz_i} + 6'd1;
    if (size_log2 > 6'(IDX_W)) begin
      size_log2 = 6'(IDX_W);
    end
    mask      = ~({IDX_W{1'b1}} << size_log2);
    next_tail = (tail_q + IDX_W'(1)) & mask;
    full      = (next_tail == head_i);
    tail_addr = ADDR_W'({base_ppn_i, 12'h000}) + ADDR_W'({tail_q, 5'b00000});
  end

  assign en_fall = en_q & ~enable_i;

  always_comb begin
    state_d  = state_q;
    pop_d    = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    set_of   = 1'b0;
    set_mf   = 1'b0;
    set_fip  = 1'b0;
    tail_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The pop is registered, so skip the cycle in which the FIFO head is still the popped record.
        if (!pop_q && !fifo_empty_i) begin
          pop_d = 1'b1;
          if (enable_i && !of_q && !mf_q) begin
            if (full) begin
              set_of = 1'b1;
            end else begin
              addr_d  = tail_addr;
              data_d  = fifo_data_i;
              state_d = ST_REQ;
            end
          end
        end
      end
      ST_REQ: begin
        if (wr_ready_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (wr_resp_valid_i) begin
          state_d = ST_IDLE;
          if (wr_resp_err_i) begin
            set_mf = 1'b1;
          end else if (enable_i) begin
            tail_adv = 1'b1;
            set_fip  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable_i) begin
      tail_d = '0;
    end else if (tail_adv) begin
      tail_d = next_tail;
    end else begin
      tail_d = tail_q;
    end

    of_d  = set_of  | (of_q  & ~clr_of_i);
    mf_d  = set_mf  | (mf_q  & ~clr_mf_i);
    fip_d = set_fip | (fip_q & ~(en_fall | clr_fip));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      tail_q  <= '0;
      pop_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      of_q    <= 1'b0;
      mf_q    <= 1'b0;
      fip_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tail_q  <= tail_d;
      pop_q   <= pop_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      of_q    <= of_d;
      mf_q    <= mf_d;
      fip_q   <= fip_d;
      en_q    <= enable_i;
    end
  end

  assign tail_o      = tail_q;
  assign fifo_pop_o  = pop_q;
  assign wr_valid_o  = (state_q == ST_REQ);
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = data_q;
  assign overflow_o  = of_q;
  assign mem_fault_o = mf_q;
  assign fip_o       = fip_q;

endmodule

// File: tb/tb_iommu_fq_writer.sv
// Testbench for iommu_fq_writer: queue-backed FIFO, scripted memory port, and an
// index-arithmetic model of the fault queue (tail, flags, expected write address).
module tb_iommu_fq_writer;
  localparam int RW = 256;
  localparam int PW = 44;
  localparam int AW = 56;
  localparam int IW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [PW-1:0] base_ppn;
  logic [4:0]    log2sz;
  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic          fifo_empty;
  logic [RW-1:0] fifo_data;
  logic          fifo_pop;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [RW-1:0] wr_data;
  logic          wr_ready;
  logic          resp_valid;
  logic          resp_err;
  logic          clr_of;
  logic          clr_mf;
  logic          ovf;
  logic          mfault;
  logic          fip;
`ifdef IOMMU_FQ_IRQ_CLR_EN
  logic          clr_fip = 1'b0;
`endif

  always #5 clk = ~clk;

  iommu_fq_writer dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .base_ppn_i(base_ppn),
    .log2sz_i(log2sz), .head_i(head), .tail_o(tail),
    .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data), .fifo_pop_o(fifo_pop),
    .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .wr_ready_i(wr_ready), .wr_resp_valid_i(resp_valid), .wr_resp_err_i(resp_err),
    .clr_of_i(clr_of), .clr_mf_i(clr_mf),
`ifdef IOMMU_FQ_IRQ_CLR_EN
    .clr_fip_i(clr_fip),
`endif
    .overflow_o(ovf), .mem_fault_o(mfault), .fip_o(fip)
  );

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [RW-1:0] fq[$];

  int      m_tail;
  int      m_head;
  int      m_log2sz;
  longint  m_base;
  bit      m_en, m_of, m_mf, m_fip;

  function automatic int entries(int l2);
    int n;
    n = l2 + 1;
    if (n > IW) n = IW;
    return 1 << n;
  endfunction

  task automatic chk(string tag, logic [RW-1:0] obs, logic [RW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  // Entered and left at a falling edge; the FIFO head advances after each edge with pop high.
  task automatic tick();
    bit popped;
    popped = fifo_pop;
    if (popped) begin
      pops++;
      chk("pop_while_empty", RW'(fifo_empty), RW'(0));
    end
    @(posedge clk);
    #1;
    if (popped && fq.size() > 0) void'(fq.pop_front());
    refresh();
    @(negedge clk);
  endtask

  task automatic check_model();
    chk("tail", RW'(tail), RW'(m_tail));
    chk("overflow", RW'(ovf), RW'(m_of));
    chk("mem_fault", RW'(mfault), RW'(m_mf));
    chk("fip", RW'(fip), RW'(m_fip));
  endtask

  task automatic set_en(bit v);
    enable = v;
    if (!v) begin
      if (m_en) m_fip = 0;
      m_tail = 0;
    end
    m_en = v;
    tick();
  endtask

  task automatic clear(bit c_of, bit c_mf);
    clr_of = c_of;
    clr_mf = c_mf;
    tick();
    clr_of = 0;
    clr_mf = 0;
    if (c_of) m_of = 0;
    if (c_mf) m_mf = 0;
  endtask

  task automatic set_head(int h);
    m_head = h;
    head   = IW'(h);
  endtask

  // Push one record and follow it to completion, comparing against the model.
  task automatic process(int delay, bit err, bit drop_en, bit clr_of_now);
    logic [RW-1:0] rec;
    logic [AW-1:0] exp_addr;
    int  p0, nt;
    bit  live, do_write, do_ovf;
    for (int i = 0; i < 8; i++) rec[i*32 +: 32] = $urandom;
    nt       = (m_tail + 1) % entries(m_log2sz);
    live     = m_en && !m_of && !m_mf;
    do_write = live && (nt != m_head);
    do_ovf   = live && (nt == m_head);
    exp_addr = AW'(m_base * 4096 + longint'(m_tail) * 32);
    if (do_ovf) m_of = 1;
    else if (clr_of_now) m_of = 0;
    p0 = pops;
    fq.push_back(rec);
    refresh();
    clr_of = clr_of_now;
    tick();
    clr_of = 0;
    if (!do_write) begin
      for (int i = 0; i < 6 && !(fq.size() == 0 && !fifo_pop); i++) begin
        chk("no_write_on_discard", RW'(wr_valid), RW'(0));
        tick();
      end
      chk("discard_pop_count", RW'(pops - p0), RW'(1));
    end else begin
      for (int i = 0; i < 6 && !wr_valid; i++) tick();
      chk("wr_valid_timeout", RW'(wr_valid), RW'(1));
      if (wr_valid) begin
        chk("wr_addr", RW'(wr_addr), RW'(exp_addr));
        chk("wr_data", wr_data, rec);
        if (drop_en) begin
          enable = 0;
          m_en   = 0;
          m_tail = 0;
          m_fip  = 0;
        end
        for (int i = 0; i < delay; i++) begin
          tick();
          chk("stall_valid", RW'(wr_valid), RW'(1));
          chk("stall_addr", RW'(wr_addr), RW'(exp_addr));
          chk("stall_data", wr_data, rec);
        end
        wr_ready = 1;
        tick();
        wr_ready = 0;
        chk("valid_drop", RW'(wr_valid), RW'(0));
        chk("write_pop_count", RW'(pops - p0), RW'(1));
        repeat ($urandom_range(0, 2)) tick();
        resp_valid = 1;
        resp_err   = err;
        tick();
        resp_valid = 0;
        resp_err   = 0;
        if (err) m_mf = 1;
        else if (m_en) begin
          m_tail = nt;
          m_fip  = 1;
        end
      end
    end
    check_model();
  endtask

  initial begin
    int l2_choices[5];
    l2_choices = '{0, 1, 2, 3, 31};
    rst_n = 0; enable = 0; base_ppn = '0; log2sz = '0; head = '0;
    wr_ready = 0; resp_valid = 0; resp_err = 0; clr_of = 0; clr_mf = 0;
    m_tail = 0; m_head = 0; m_log2sz = 0; m_base = 0;
    m_en = 0; m_of = 0; m_mf = 0; m_fip = 0;
    refresh();
    repeat (2) @(negedge clk);
    chk("rst_tail", RW'(tail), RW'(0));
    chk("rst_pop", RW'(fifo_pop), RW'(0));
    chk("rst_valid", RW'(wr_valid), RW'(0));
    chk("rst_addr", RW'(wr_addr), RW'(0));
    chk("rst_data", wr_data, RW'(0));
    chk("rst_flags", RW'({ovf, mfault, fip}), RW'(0));
    rst_n = 1;
    @(negedge clk);

    // Normal write: 16-entry queue at PPN 0x100
    base_ppn = PW'(64'h100); m_base = 64'h100;
    log2sz = 5'd3; m_log2sz = 3;
    set_head(0);
    set_en(1);
    process(2, 0, 0, 0);
    chk("first_tail", RW'(tail), RW'(1));
    chk("first_fip", RW'(fip), RW'(1));

    // Fill to tail 15, then wrap with head at 3
    while (m_tail != 15) process($urandom_range(0, 3), 0, 0, 0);
    set_head(3);
    process(1, 0, 0, 0);
    chk("wrap_tail", RW'(tail), RW'(0));

    // Overflow (a clear in the same cycle loses), stays sticky, then cleared
    process(0, 0, 0, 0);
    process(0, 0, 0, 0);
    process(0, 0, 0, 1);
    chk("overflow_set", RW'(ovf), RW'(1));
    process(0, 0, 0, 0);
    clear(1, 0);
    set_head(0);
    process(1, 0, 0, 0);

    // Memory fault, discard while set, then cleared
    process(1, 1, 0, 0);
    chk("mf_set", RW'(mfault), RW'(1));
    process(0, 0, 0, 0);
    clear(0, 1);
    process(0, 0, 0, 0);

    // Backpressure
    process(10, 0, 0, 0);

    // Disable while the request is outstanding
    process(2, 0, 1, 0);
    chk("disable_tail", RW'(tail), RW'(0));
    chk("disable_fip", RW'(fip), RW'(0));
    process(0, 0, 0, 0);
    set_en(1);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        m_log2sz = l2_choices[$urandom_range(0, 4)];
        log2sz   = 5'(m_log2sz);
      end
      if ($urandom_range(0, 3) == 0) set_head($urandom_range(0, 7) % entries(m_log2sz));
      if ($urandom_range(0, 4) == 0) clear($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 11) == 0) set_en(!m_en);
      process($urandom_range(0, 3), $urandom_range(0, 7) == 0,
              $urandom_range(0, 14) == 0, $urandom_range(0, 5) == 0);
      if (!m_en && $urandom_range(0, 2) == 0) set_en(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
